// File: rtl/hub75_fb_writer.sv
// Byte-stream to framebuffer writer for the HUB75 path: packs three bytes per
// word, writes sequential addresses and flips the double buffer at frame end.
module hub75_fb_writer #(
    parameter int NUM_WORDS = 16384,
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 20
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_sof,
    output logic              in_ready,
    input  logic              frame_start,
    output logic [DATA_W-1:0] fb_wdata,
    output logic [ADDR_W-1:0] fb_waddr,
    output logic              fb_we,
    output logic              selection,
    output logic              frame_done,
    output logic              err_sync
);

    typedef enum logic [1:0] {IDLE, RECV, SWAP_WAIT} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);

    state_t              state_q, state_d;
    logic [1:0]          lane_q, lane_d;
    logic [ADDR_W-1:0]   widx_q, widx_d;
    logic [7:0]          b0_q, b0_d, b1_q, b1_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic                we_q, we_d;
    logic                sel_q, sel_d;
    logic                fd_q, fd_d;
    logic                err_q, err_d;
    logic                accept;

    assign in_ready   = rst && (state_q != SWAP_WAIT);
    assign accept     = in_valid && in_ready;
    assign fb_wdata   = wdata_q;
    assign fb_waddr   = waddr_q;
    assign fb_we      = we_q;
    assign selection  = sel_q;
    assign frame_done = fd_q;
    assign err_sync   = err_q;

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        widx_d  = widx_q;
        b0_d    = b0_q;
        b1_d    = b1_q;
        wdata_d = wdata_q;
        waddr_d = waddr_q;
        we_d    = 1'b0;
        sel_d   = sel_q;
        fd_d    = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && in_sof) begin
                    b0_d    = in_data;
                    lane_d  = 2'd1;
                    widx_d  = '0;
                    state_d = RECV;
                end
            end
            RECV: begin
                if (accept) begin
                    if (in_sof) begin
                        // Restart the frame; only a restart at word 0 lane 0 is clean.
                        err_d  = (lane_q != 2'd0) || (widx_q != '0);
                        b0_d   = in_data;
                        lane_d = 2'd1;
                        widx_d = '0;
                    end else begin
                        case (lane_q)
                            2'd0: begin
                                b0_d   = in_data;
                                lane_d = 2'd1;
                            end
                            2'd1: begin
                                b1_d   = in_data;
                                lane_d = 2'd2;
                            end
                            default: begin
                                // Little-endian pack; upper bits of the third byte are dropped.
                                wdata_d = DATA_W'({in_data, b1_q, b0_q});
                                waddr_d = widx_q;
                                we_d    = 1'b1;
                                lane_d  = 2'd0;
                                if (widx_q == LAST_IDX) begin
                                    widx_d  = '0;
                                    state_d = SWAP_WAIT;
                                end else begin
                                    widx_d = widx_q + ADDR_W'(1);
                                end
                            end
                        endcase
                    end
                end
            end
            SWAP_WAIT: begin
                if (frame_start) begin
                    sel_d   = ~sel_q;
                    fd_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            lane_q  <= 2'd0;
            widx_q  <= '0;
            b0_q    <= 8'd0;
            b1_q    <= 8'd0;
            wdata_q <= '0;
            waddr_q <= '0;
            we_q    <= 1'b0;
            sel_q   <= 1'b0;
            fd_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            widx_q  <= widx_d;
            b0_q    <= b0_d;
            b1_q    <= b1_d;
            wdata_q <= wdata_d;
            waddr_q <= waddr_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            fd_q    <= fd_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_hub75_fb_writer.sv
// Scoreboard bench for hub75_fb_writer with a 4-word frame.
module tb_hub75_fb_writer;

    localparam int NW = 4;
    localparam int AW = 14;
    localparam int DW = 20;

    logic          sys_clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    in_data = 8'd0;
    logic          in_valid = 1'b0;
    logic          in_sof = 1'b0;
    logic          frame_start = 1'b0;
    logic          in_ready;
    logic [DW-1:0] fb_wdata;
    logic [AW-1:0] fb_waddr;
    logic          fb_we;
    logic          selection;
    logic          frame_done;
    logic          err_sync;

    hub75_fb_writer #(.NUM_WORDS(NW), .ADDR_W(AW), .DATA_W(DW)) dut (
        .sys_clk(sys_clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_sof(in_sof), .in_ready(in_ready), .frame_start(frame_start),
        .fb_wdata(fb_wdata), .fb_waddr(fb_waddr), .fb_we(fb_we),
        .selection(selection), .frame_done(frame_done), .err_sync(err_sync)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int err_cnt = 0;
    int fd_cnt = 0;
    logic exp_sel = 1'b0;
    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] exp_w;
    int wcyc[$];

    function automatic logic [DW-1:0] pack(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        return {c[3:0], b, a};
    endfunction

    always @(posedge sys_clk) cyc++;

    // Output monitor: pops the scoreboard on every write.
    always @(negedge sys_clk) begin
        if (err_sync) err_cnt++;
        if (frame_done) fd_cnt++;
        if (fb_we) begin
            wcyc.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write got addr=%0h data=%0h required no write", fb_waddr, fb_wdata);
            end else begin
                exp_w = exp_q.pop_front();
                if ({fb_waddr, fb_wdata} !== exp_w) begin
                    failures++;
                    $display("FAIL fb_write got addr=%0h data=%0h required addr=%0h data=%0h",
                             fb_waddr, fb_wdata, exp_w[AW+DW-1:DW], exp_w[DW-1:0]);
                end
            end
        end
    end

    // All tasks are entered and left 1 time unit after a rising edge.
    task automatic send_byte(input logic [7:0] d, input logic s);
        int n;
        in_data = d;
        in_sof = s;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge sys_clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout got in_ready=0 required 1 within 50 cycles");
        end
        @(posedge sys_clk); #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_sof = 1'b0;
        repeat (n) begin @(posedge sys_clk); #1; end
    endtask

    task automatic gap(input bit en);
        if (en) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge sys_clk); #1; end
        end
    endtask

    task automatic send_frame(input logic [7:0] base, input bit gaps, input bit fs_on_last);
        logic [7:0] b [3];
        for (int i = 0; i < 3 * NW; i++) begin
            b[i % 3] = base + 8'(i);
            if (i % 3 == 2) exp_q.push_back({AW'(i / 3), pack(b[0], b[1], b[2])});
            gap(gaps);
            if (fs_on_last && i == 3 * NW - 1) frame_start = 1'b1;
            send_byte(base + 8'(i), i == 0);
            frame_start = 1'b0;
        end
        in_valid = 1'b0;
        in_sof = 1'b0;
    endtask

    task automatic swap_pulse();
        int fd0;
        fd0 = fd_cnt;
        frame_start = 1'b1;
        @(posedge sys_clk); #1;
        frame_start = 1'b0;
        exp_sel = ~exp_sel;
        checks++;
        if (selection !== exp_sel || frame_done !== 1'b1 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL swap got sel=%b fd=%b rdy=%b required sel=%b fd=1 rdy=1",
                     selection, frame_done, in_ready, exp_sel);
        end
        @(posedge sys_clk); #1;
        checks++;
        if (frame_done !== 1'b0 || fd_cnt - fd0 != 1) begin
            failures++;
            $display("FAIL frame_done_pulse got fd=%b pulses=%0d required fd=0 pulses=1", frame_done, fd_cnt - fd0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_valid = 1'b1;
        in_sof = 1'b1;
        in_data = 8'hAA;
        repeat (3) @(posedge sys_clk);
        #1;
        checks++;
        if ({in_ready, fb_we, selection, frame_done, err_sync} !== 5'b0 || fb_waddr !== '0 || fb_wdata !== '0) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%b we=%b sel=%b fd=%b err=%b addr=%0h data=%0h required all 0",
                     in_ready, fb_we, selection, frame_done, err_sync, fb_waddr, fb_wdata);
        end
        in_valid = 1'b0;
        in_sof = 1'b0;
        rst = 1'b1;
        @(posedge sys_clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release got in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_full_frame();
        wcyc.delete();
        send_frame(8'h01, 1'b0, 1'b0);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL swap_wait_ready got %b required 0", in_ready);
        end
        idle(4);
        checks++;
        if (wcyc.size() != NW) begin
            failures++;
            $display("FAIL write_count got %0d required %0d", wcyc.size(), NW);
        end else begin
            for (int i = 1; i < NW; i++) begin
                checks++;
                if (wcyc[i] - wcyc[i-1] != 3) begin
                    failures++;
                    $display("FAIL write_spacing got %0d required 3", wcyc[i] - wcyc[i-1]);
                end
            end
        end
        checks++;
        if (selection !== exp_sel || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL hold_swap got sel=%b rdy=%b required sel=%b rdy=0", selection, in_ready, exp_sel);
        end
        swap_pulse();
    endtask

    task automatic test_gaps();
        for (int i = 0; i < 5; i++) begin
            gap(1'b1);
            send_byte(8'hE0 + 8'(i), 1'b0);
        end
        idle(2);
        send_frame(8'h01, 1'b1, 1'b0);
        idle(3);
        swap_pulse();
    endtask

    task automatic test_resync();
        int e0;
        e0 = err_cnt;
        exp_q.push_back({AW'(0), pack(8'd1, 8'd2, 8'd3)});
        exp_q.push_back({AW'(1), pack(8'd4, 8'd5, 8'd6)});
        for (int i = 1; i <= 6; i++) send_byte(8'(i), i == 1);
        checks++;
        if (err_sync !== 1'b0) begin
            failures++;
            $display("FAIL sof_clean got err_sync=%b required 0", err_sync);
        end
        exp_q.push_back({AW'(0), pack(8'd7, 8'd8, 8'd9)});
        send_byte(8'd7, 1'b1);
        checks++;
        if (err_sync !== 1'b1) begin
            failures++;
            $display("FAIL resync_word_boundary got err_sync=%b required 1", err_sync);
        end
        for (int i = 8; i <= 11; i++) send_byte(8'(i), 1'b0);
        for (int w = 0; w < NW; w++)
            exp_q.push_back({AW'(w), pack(8'(12 + 3*w), 8'(13 + 3*w), 8'(14 + 3*w))});
        send_byte(8'd12, 1'b1);
        checks++;
        if (err_sync !== 1'b1) begin
            failures++;
            $display("FAIL resync_partial got err_sync=%b required 1", err_sync);
        end
        for (int i = 13; i <= 23; i++) send_byte(8'(i), 1'b0);
        idle(2);
        checks++;
        if (err_cnt - e0 != 2) begin
            failures++;
            $display("FAIL err_pulses got %0d required 2", err_cnt - e0);
        end
        swap_pulse();
    endtask

    task automatic test_mid_reset();
        exp_q.push_back({AW'(0), pack(8'h51, 8'h52, 8'h53)});
        for (int i = 0; i < 5; i++) send_byte(8'h51 + 8'(i), i == 0);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        exp_sel = 1'b0;
        checks++;
        if ({in_ready, fb_we, selection, frame_done, err_sync} !== 5'b0 || fb_waddr !== '0 || fb_wdata !== '0) begin
            failures++;
            $display("FAIL mid_reset got rdy=%b we=%b sel=%b addr=%0h data=%0h required all 0",
                     in_ready, fb_we, selection, fb_waddr, fb_wdata);
        end
        @(posedge sys_clk); #1;
        rst = 1'b1;
        @(posedge sys_clk); #1;
        send_frame(8'h60, 1'b0, 1'b0);
        idle(2);
        swap_pulse();
    endtask

    task automatic test_swap_race();
        logic s0;
        int fd0;
        s0 = exp_sel;
        fd0 = fd_cnt;
        send_frame(8'h90, 1'b0, 1'b1);
        idle(20);
        checks++;
        if (selection !== s0 || fd_cnt != fd0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL swap_race got sel=%b fd_pulses=%0d rdy=%b required sel=%b fd_pulses=0 rdy=0",
                     selection, fd_cnt - fd0, in_ready, s0);
        end
        swap_pulse();
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_gaps();
        test_resync();
        test_mid_reset();
        test_swap_race();
        idle(5);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_writes got %0d outstanding required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
